dds_wavetable_player: RTL and testbench

//   Parametrised DDS waveform generator: byte-command interface loads a sample table,

---
 rtl/dds_pkg.sv | 19 +
 rtl/dds_wavetable_player_ram.sv | 29 ++
 rtl/dds_wavetable_player.sv | 143 ++++++++++++++
 tb/tb_dds_wavetable_player.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared constants for dds_wavetable_player.
//   OP_*        command opcodes recognised by the byte-command FSM
//   dds_state_e command FSM states
package dds_pkg;

  localparam logic [7:0] OP_LOAD = 8'hA0;
  localparam logic [7:0] OP_TUNE = 8'hB0;
  localparam logic [7:0] OP_RUN  = 8'hC0;
  localparam logic [7:0] OP_STOP = 8'hC1;
  localparam logic [7:0] OP_AMP  = 8'hD0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TUNE,
    ST_AMP
  } dds_state_e;

endpackage

// File: rtl/dds_wavetable_player_ram.sv
// dds_wavetable_player_ram: simple dual-port RAM, one write port, one
// synchronous read port. A read and a write to the same address in the same
// cycle return the old contents.
//   clk      in  clock
//   we       in  write enable
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_addr  in  read address, sampled every clk
//   rd_data  out registered read data (1 clk latency)
module dds_wavetable_player_ram #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dds_wavetable_player.sv
// dds_wavetable_player: DDS waveform generator driven by a byte-command stream.
// A command FSM loads the wavetable, sets the phase tuning word and starts or
// stops playback; a phase accumulator indexes the table every clock.
//   clk        in  clock, all logic on posedge
//   rst        in  asynchronous active-high reset
//   rx_dv      in  one-cycle strobe, rx_byte valid
//   rx_byte    in  command / payload byte
//   dds_out    out registered DAC sample
//   running    out playback active
//   busy       out command FSM is collecting payload bytes
//   load_count out next table write address
// Build option: define DDS_AMPLITUDE_EN to add the amplitude opcode (0xD0 +
// one byte) and output scaling dds_out = (sample * (amp+1)) >> 8.
module dds_wavetable_player
  import dds_pkg::*;
#(
  parameter int DATA_W  = 6,
  parameter int ADDR_W  = 8,
  parameter int PHASE_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic [DATA_W-1:0] dds_out,
  output logic              running,
  output logic              busy,
  output logic [ADDR_W-1:0] load_count
);

  localparam int TB_N = PHASE_W / 8;
  localparam int BC_W = (TB_N > 1) ? $clog2(TB_N) : 1;

  dds_state_e         state, state_nx;
  logic [BC_W-1:0]    tbyte;
  logic [PHASE_W-1:0] shadow, tune, phase;
  logic               tune_commit;
  logic               rd_vld;
  logic [DATA_W-1:0]  rd_data, sample;
  logic               idle_cmd, op_run, op_stop, tune_last, ram_we;

  assign idle_cmd  = (state == ST_IDLE) && rx_dv;
  assign op_run    = idle_cmd && (rx_byte == OP_RUN);
  assign op_stop   = idle_cmd && (rx_byte == OP_STOP);
  assign tune_last = (tbyte == BC_W'(TB_N - 1));
  assign ram_we    = (state == ST_LOAD) && rx_dv;
  assign busy      = (state != ST_IDLE);

  // ---------------- command FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (rx_dv) begin
          if (rx_byte == OP_LOAD)      state_nx = ST_LOAD;
          else if (rx_byte == OP_TUNE) state_nx = ST_TUNE;
`ifdef DDS_AMPLITUDE_EN
          else if (rx_byte == OP_AMP)  state_nx = ST_AMP;
`endif
        end
      end
      // load_count wraps to 0 on the last byte, so LOAD ends there
      ST_LOAD: if (rx_dv && load_count == '1) state_nx = ST_IDLE;
      ST_TUNE: if (rx_dv && tune_last)        state_nx = ST_IDLE;
      ST_AMP:  if (rx_dv)                     state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // ---------------- payload capture ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_count  <= '0;
      tbyte       <= '0;
      shadow      <= '0;
      tune_commit <= 1'b0;
      tune        <= '0;
    end else begin
      if (ram_we) load_count <= load_count + 1'b1;
      // little-endian: first payload byte lands in bits [7:0]
      if (state == ST_TUNE && rx_dv) begin
        shadow[8*int'(tbyte) +: 8] <= rx_byte;
        tbyte <= tune_last ? '0 : tbyte + 1'b1;
      end
      // whole word moves into tune in one step, a cycle after the last byte
      tune_commit <= (state == ST_TUNE) && rx_dv && tune_last;
      if (tune_commit) tune <= shadow;
    end
  end

  // ---------------- accumulator / output ----------------
  dds_wavetable_player_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (load_count),
    .wr_data (rx_byte[7 -: DATA_W]),
    .rd_addr (phase[PHASE_W-1 -: ADDR_W]),
    .rd_data (rd_data)
  );

`ifdef DDS_AMPLITUDE_EN
  logic [7:0]        amp;
  logic [8:0]        amp_p1;
  logic [DATA_W+8:0] prod;

  assign amp_p1 = {1'b0, amp} + 9'd1;
  assign prod   = {9'd0, rd_data} * {{DATA_W{1'b0}}, amp_p1};
  assign sample = DATA_W'(prod >> 8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        amp <= 8'hFF;
    else if (state == ST_AMP && rx_dv) amp <= rx_byte;
  end
`else
  assign sample = rd_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      phase   <= '0;
      rd_vld  <= 1'b0;
      dds_out <= '0;
    end else begin
      if (op_run)  running <= 1'b1;
      if (op_stop) running <= 1'b0;

      if (op_stop)      phase <= '0;
      else if (running) phase <= phase + tune;

      // rd_vld marks rd_data as read while running; clearing it on STOP keeps
      // the stale in-flight sample off the pins.
      rd_vld  <= running && !op_stop;
      dds_out <= (rd_vld && !op_stop) ? sample : '0;
    end
  end

endmodule

// File: tb/tb_dds_wavetable_player.sv
// tb_dds_wavetable_player: directed, self-checking bench for dds_wavetable_player.
module tb_dds_wavetable_player;

  localparam int DATA_W  = 6;
  localparam int ADDR_W  = 8;
  localparam int PHASE_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_dv = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic [DATA_W-1:0] dds_out;
  logic              running;
  logic              busy;
  logic [ADDR_W-1:0] load_count;

  int n_cmp = 0;
  int n_bad = 0;

  dds_wavetable_player #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PHASE_W(PHASE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_dv      (rx_dv),
    .rx_byte    (rx_byte),
    .dds_out    (dds_out),
    .running    (running),
    .busy       (busy),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drive one byte for one clock; returns on the negedge after it is consumed
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  logic [7:0]        tb4 [5];
  logic [DATA_W-1:0] prev, cur;
  int                amp_exp;

  initial begin
    tb4[0] = 8'hB0; tb4[1] = 8'h00; tb4[2] = 8'h00; tb4[3] = 8'h00; tb4[4] = 8'h02;

    // reset state
    #12;
    chk("rst_dds",  32'(dds_out), 0);
    chk("rst_run",  32'(running), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_lc",   32'(load_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // non-opcode byte in IDLE
    send_byte(8'h55);
    chk("idle55_busy", 32'(busy), 0);
    chk("idle55_run",  32'(running), 0);
    chk("idle55_lc",   32'(load_count), 0);

    // full table load, byte i<<2 -> sample i&63
    send_byte(8'hA0);
    chk("load_busy0", 32'(busy), 1);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i << 2));
      chk("load_lc",   32'(load_count), 32'((i + 1) % 256));
      chk("load_busy", 32'(busy), (i < 255) ? 1 : 0);
    end

    // tune = 0x01000000, then RUN: one index step per clk
    send_byte(8'hB0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("tune_busy", 32'(busy), 1);
    send_byte(8'h01);
    chk("tune_done", 32'(busy), 0);
    send_byte(8'hC0);
    chk("run_flag", 32'(running), 1);
    chk("run_dds0", 32'(dds_out), 0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("ramp", 32'(dds_out), (k >= 2) ? 32'(k - 2) : 0);
    end

    // retune to 0x02000000 while running; step changes from 1 to 2 exactly once
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      cur = dds_out;
      if (c >= 1) chk("retune_step", 32'(DATA_W'(cur - prev)), (c >= 9) ? 2 : 1);
      prev = cur;
      rx_dv   = (c < 5);
      rx_byte = (c < 5) ? tb4[c] : 8'h00;
    end
    rx_dv = 1'b0;

    // STOP
    send_byte(8'hC1);
    chk("stop_dds",  32'(dds_out), 0);
    chk("stop_run",  32'(running), 0);
    @(negedge clk);
    chk("stop_dds2", 32'(dds_out), 0);

    // amplitude opcode (ignored unless the option is built in)
`ifdef DDS_AMPLITUDE_EN
    send_byte(8'hD0);
    chk("amp_busy", 32'(busy), 1);
    send_byte(8'h7F);
    chk("amp_done", 32'(busy), 0);
    amp_exp = 31;
`else
    send_byte(8'hD0);
    chk("amp_ign", 32'(busy), 0);
    send_byte(8'h7F);
    chk("amp_ign2", 32'(busy), 0);
    amp_exp = 62;
`endif
    // tune 0x3E000000; RUN after STOP starts at table[0], then table[62]
    send_byte(8'hB0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h3E);
    send_byte(8'hC0);
    @(negedge clk);
    chk("amp_k1", 32'(dds_out), 0);
    @(negedge clk);
    chk("amp_k2", 32'(dds_out), 0);
    @(negedge clk);
    chk("amp_s62", 32'(dds_out), 32'(amp_exp));

    // LOAD while running, then async reset on payload byte 10
    send_byte(8'hA0);
    for (int i = 0; i < 10; i++) send_byte(8'(i << 2));
    chk("pre_lc",   32'(load_count), 10);
    chk("pre_busy", 32'(busy), 1);
    chk("pre_run",  32'(running), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_dds",  32'(dds_out), 0);
    chk("arst_run",  32'(running), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_lc",   32'(load_count), 0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h55);
    chk("post55_busy", 32'(busy), 0);
    chk("post55_lc",   32'(load_count), 0);
    chk("post55_run",  32'(running), 0);
    @(negedge clk);
    chk("post55_dds",  32'(dds_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
